// File: rtl/mul_share_arb.sv
// mul_share_arb
//   Round-robin arbiter that shares one saturating 11-bit signed multiplier
//   among NREQ requesters. One operand pair is accepted at a time. The pair is
//   multiplied in a single CALC cycle, and the product is clamped to [-SAT, +SAT].
//   The result is then held for the owning requester until that requester
//   acknowledges it.
//
// Ports
//   clk, rst    : system clock, synchronous active-high reset
//   req_valid   : per-requester operand-pair valid
//   req_acc     : packed signed operands, requester i at [11*i+10 : 11*i]
//   req_arg     : packed signed operands, same packing
//   req_ready   : one-hot grant (combinational, IDLE only)
//   resp_valid  : one-hot result-available flag for the owner
//   resp_data   : clamped signed product
//   resp_sat    : product was clamped
//   resp_ack    : per-requester result consume (only the owner bit counts)
//   busy        : high while in CALC or RESP
module mul_share_arb #(
  parameter int NREQ = 4,
  parameter int SAT  = 999
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*11-1:0]       req_acc,
  input  logic [NREQ*11-1:0]       req_arg,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          resp_valid,
  output logic signed [10:0]       resp_data,
  output logic                     resp_sat,
  input  logic [NREQ-1:0]          resp_ack,
  output logic                     busy
);

  localparam int DATA_W = 11;
  localparam int PROD_W = 2 * DATA_W;
  localparam int IDX_W  = $clog2(NREQ);

  localparam logic [IDX_W-1:0]         LG_RST = IDX_W'(NREQ - 1);
  localparam logic signed [PROD_W-1:0] SAT_P  = PROD_W'(SAT);
  localparam logic signed [PROD_W-1:0] NSAT_P = -SAT_P;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t                    state, state_nx;
  logic [IDX_W-1:0]          last_grant;
  logic [IDX_W-1:0]          owner;
  logic [IDX_W-1:0]          win_idx;
  logic                      win_found;
  logic                      xfer;
  int                        cand;
  logic signed [DATA_W-1:0]  op_a_p0, op_b_p0;
  logic signed [PROD_W-1:0]  prod;

  function automatic logic signed [DATA_W-1:0] sat_clamp(
    input logic signed [PROD_W-1:0] p
  );
    if (p > SAT_P)       return SAT_P[DATA_W-1:0];
    else if (p < NSAT_P) return NSAT_P[DATA_W-1:0];
    else                 return p[DATA_W-1:0];
  endfunction

  function automatic logic is_clamped(input logic signed [PROD_W-1:0] p);
    return (p > SAT_P) || (p < NSAT_P);
  endfunction

  // Rotating priority search that starts just after the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (!win_found && req_valid[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    resp_valid = '0;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        // The grant goes to a requester that is already valid, so any grant is a transfer.
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          xfer               = 1'b1;
          state_nx           = CALC;
        end
      end
      CALC: state_nx = RESP;
      RESP: begin
        resp_valid[owner] = 1'b1;
        if (resp_ack[owner]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Stage p0: operands captured on the transfer edge. They are not reset
  // because a reset abort discards them.
  always_ff @(posedge clk) begin
    if (xfer) begin
      op_a_p0 <= $signed(req_acc[int'(win_idx)*DATA_W +: DATA_W]);
      op_b_p0 <= $signed(req_arg[int'(win_idx)*DATA_W +: DATA_W]);
    end
  end

  assign prod = op_a_p0 * op_b_p0;

  // Stage p1: the clamped product is registered on leaving CALC and held through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= LG_RST;
      owner      <= '0;
      resp_data  <= '0;
      resp_sat   <= 1'b0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        owner      <= win_idx;
        last_grant <= win_idx;
      end
      if (state == CALC) begin
        resp_data <= sat_clamp(prod);
        resp_sat  <= is_clamped(prod);
      end
    end
  end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one saturating 11-bit signed multiplier among NREQ node requesters.
- The multiply saturates to ±999.
- Sits between node ALUs and a single shared multiplier instance inside the block.
- Accepts one operand pair at a time, registers the clamped product and flags saturation.
- Holds the result for the owning requester until that requester acknowledges it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SAT, 999, saturation magnitude; products clamp to [-SAT, +SAT].

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester operand-pair valid.
- req_acc  input  NREQ*11  packed signed acc operands; requester i uses bits [11*i+10 : 11*i].
- req_arg  input  NREQ*11  packed signed arg1 operands, same packing.
- req_ready  output  NREQ  one-hot grant; transfer occurs when req_valid[i] & req_ready[i].
- resp_valid  output  NREQ  one-hot; result available for requester i.
- resp_data  output  11  signed clamped product.
- resp_sat  output  1  1 when the product was clamped.
- resp_ack  input  NREQ  requester consumes its result.
- busy  output  1  high in CALC or RESP.

Behaviour:
- States: IDLE, CALC, RESP. Reset goes to IDLE.
- Reset values: req_ready=0, resp_valid=0, resp_data=0, resp_sat=0, busy=0, last_grant=NREQ-1, so requester 0 has first priority.
- IDLE:
  - Winner g is the first i with req_valid[i], searching from last_grant+1 upward, wrapping modulo NREQ.
  - req_ready is combinational in IDLE: one-hot at g when any req_valid is set; all zero otherwise and in every other state.
  - On the edge where the transfer occurs: latch req_acc/req_arg slice g into op_a/op_b, owner<=g, last_grant<=g, go to CALC.
- CALC (exactly 1 cycle):
  - Compute the 22-bit signed product of op_a and op_b.
  - If product > SAT, resp_data<=SAT. If product < -SAT, resp_data<=-SAT. Otherwise resp_data<=product[10:0].
  - resp_sat<=1 if clamped, else 0.
  - Go to RESP.
- RESP:
  - resp_valid[owner]=1; resp_data and resp_sat stable.
  - When resp_ack[owner]=1 at an edge: go to IDLE. resp_valid drops next cycle; resp_data/resp_sat hold their last value.
  - resp_ack on non-owner bits is ignored in all states.
  - resp_ack in IDLE or CALC has no effect.
- Latency: transfer edge E0 -> result visible after E1. Earliest ack at E2. Next grant is combinational in the cycle after E2, with the next transfer at E3. Peak throughput is one op per 3 cycles.
- Fairness: a requester that holds req_valid is granted within NREQ transactions. Requesters must hold valid and operands stable until ready. A valid dropped before grant is simply skipped, with no error.
- Requester changes in IDLE: req_valid changes between cycles re-evaluate the winner combinationally. last_grant only updates on an actual transfer.
- Boundary cases:
  - -SAT*-SAT = +998001 -> SAT.
  - -1024*-1024 (raw 11-bit minimum operands) -> SAT.
  - 0 * anything -> 0, sat=0.
  - Product exactly ±SAT -> passed through, sat=0.
- Reset mid-operation (CALC or RESP): abort. The result is lost, no resp_valid is seen, last_grant returns to NREQ-1, and the held operands are discarded.
- busy = (state != IDLE).

Test Plan:
- Single request: req_valid=0001, acc=25, arg=-30 -> req_ready=0001 same cycle; resp_valid=0001 one cycle after transfer; resp_data=-750, resp_sat=0; ack -> IDLE, busy=0.
- Saturation: acc=100, arg=50 -> resp_data=999, resp_sat=1. acc=-100, arg=50 -> -999, sat=1. acc=-1024, arg=-1024 -> 999, sat=1. acc=27, arg=37 (=999) -> 999, sat=0.
- Round-robin: all four valid continuously, ack immediately each time -> grant order 0,1,2,3,0. With only requesters 1 and 3 valid after granting 1 -> next grant is 3, then 1.
- Held response: no ack for 5 cycles -> resp_valid, resp_data and resp_sat stable. No req_ready during that time despite other valids. resp_ack on a non-owner bit is ignored.
- Reset mid-op: assert rst in CALC and separately in RESP -> next cycle all outputs are at reset values. The next grant goes to requester 0 even if requester 2 was last served.
- Valid withdrawn: req_valid[2] pulses for one cycle while busy and is then dropped -> never granted; the arbiter stays in IDLE with req_ready=0.
